// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready input and an optional sweep sequencer.
// Define DECODER_SCAN_EN to build the scan sequencer (SCAN/DONE states, code and dwell counters).
module decoder_nto2n_seq #(
    parameter int unsigned N     = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_addr,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_done,
    output logic [2**N-1:0]   D,
    output logic              out_valid
);
    localparam int unsigned NumOut = 2 ** N;

    logic [NumOut-1:0] d_q, d_d;
    logic              out_valid_q, out_valid_d;

    assign D         = d_q;
    assign out_valid = out_valid_q;

`ifdef DECODER_SCAN_EN
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);
    localparam logic [N-1:0]  CodeLast  = {N{1'b1}};

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [N-1:0]  code_q, code_d;
    logic [N-1:0]  code_inc;

    assign code_inc = code_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            dwell_q     <= '0;
            code_q      <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            code_q      <= code_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        code_d      = code_q;
        d_d         = d_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // scan_start wins; in_ready is low so the address stays pending
                if (scan_start) begin
                    state_d     = StScan;
                    code_d      = '0;
                    dwell_d     = '0;
                    d_d         = NumOut'(1);
                    out_valid_d = 1'b1;
                end else if (in_valid) begin
                    d_d          = '0;
                    d_d[in_addr] = 1'b1;
                    out_valid_d  = 1'b1;
                end
            end
            StScan: begin
                if (dwell_q == DwellLast) begin
                    if (code_q == CodeLast) begin
                        state_d = StDone;
                        d_d     = '0;
                    end else begin
                        code_d           = code_inc;
                        dwell_d          = '0;
                        d_d              = '0;
                        d_d[code_inc]    = 1'b1;
                        out_valid_d      = 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle) && !scan_start;
        scan_busy = (state_q == StScan);
        scan_done = (state_q == StDone);
    end
`else
    logic unused_scan_start;
    assign unused_scan_start = scan_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        d_d         = d_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            d_d          = '0;
            d_d[in_addr] = 1'b1;
            out_valid_d  = 1'b1;
        end
    end

    always_comb begin
        in_ready  = 1'b1;
        scan_busy = 1'b0;
        scan_done = 1'b0;
    end
`endif

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed bench for decoder_nto2n_seq: table-driven direct decode plus hand-written scan sequences.
// Scan checks are built when DECODER_SCAN_EN is defined; otherwise scan_start is checked to be inert.
module tb_decoder_nto2n_seq;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_addr;
    logic        scan_start;
    logic        scan_busy;
    logic        scan_done;
    logic [7:0]  d;
    logic        out_valid;

    logic        w_valid;
    logic        w_ready;
    logic [4:0]  w_addr;
    logic        w_scan_start;
    logic        w_busy;
    logic        w_done;
    logic [31:0] w_d;
    logic        w_ov;

    int checks = 0;
    int errors = 0;

    decoder_nto2n_seq #(.N(3), .DWELL(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .scan_start (scan_start),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .D          (d),
        .out_valid  (out_valid)
    );

    decoder_nto2n_seq #(.N(5), .DWELL(2)) u_wide (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (w_valid),
        .in_ready   (w_ready),
        .in_addr    (w_addr),
        .scan_start (w_scan_start),
        .scan_busy  (w_busy),
        .scan_done  (w_done),
        .D          (w_d),
        .out_valid  (w_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [2:0] addr;
        logic [7:0] exp_d;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_d;

        reset = 1'b1; in_valid = 1'b0; in_addr = '0; scan_start = 1'b0;
        w_valid = 1'b0; w_addr = '0; w_scan_start = 1'b0;

        // Reset
        step();
        step();
        check("rst_d", 64'(d), 64'h00);
        check("rst_ov", 64'(out_valid), 64'h0);
        check("rst_busy", 64'(scan_busy), 64'h0);
        check("rst_done", 64'(scan_done), 64'h0);
        check("rst_ready", 64'(in_ready), 64'h1);
        reset = 1'b0;

        // Single decode of 5 then hold, then back-to-back 0..7
        vecs[0]  = '{valid: 1'b1, addr: 3'd5, exp_d: 8'h20, exp_ov: 1'b1};
        vecs[1]  = '{valid: 1'b0, addr: 3'd2, exp_d: 8'h20, exp_ov: 1'b0};
        vecs[2]  = '{valid: 1'b1, addr: 3'd0, exp_d: 8'h01, exp_ov: 1'b1};
        vecs[3]  = '{valid: 1'b1, addr: 3'd1, exp_d: 8'h02, exp_ov: 1'b1};
        vecs[4]  = '{valid: 1'b1, addr: 3'd2, exp_d: 8'h04, exp_ov: 1'b1};
        vecs[5]  = '{valid: 1'b1, addr: 3'd3, exp_d: 8'h08, exp_ov: 1'b1};
        vecs[6]  = '{valid: 1'b1, addr: 3'd4, exp_d: 8'h10, exp_ov: 1'b1};
        vecs[7]  = '{valid: 1'b1, addr: 3'd5, exp_d: 8'h20, exp_ov: 1'b1};
        vecs[8]  = '{valid: 1'b1, addr: 3'd6, exp_d: 8'h40, exp_ov: 1'b1};
        vecs[9]  = '{valid: 1'b1, addr: 3'd7, exp_d: 8'h80, exp_ov: 1'b1};
        vecs[10] = '{valid: 1'b0, addr: 3'd0, exp_d: 8'h80, exp_ov: 1'b0};

        for (int i = 0; i < 11; i++) begin
            in_valid = vecs[i].valid;
            in_addr  = vecs[i].addr;
            step();
            check($sformatf("vec%0d_d", i), 64'(d), 64'(vecs[i].exp_d));
            check($sformatf("vec%0d_ov", i), 64'(out_valid), 64'(vecs[i].exp_ov));
        end
        in_valid = 1'b0;

`ifdef DECODER_SCAN_EN
        // Start collision: scan_start beats in_valid, and in_valid stays high through the scan
        scan_start = 1'b1; in_valid = 1'b1; in_addr = 3'd6;
        #1;
        check("coll_ready", 64'(in_ready), 64'h0);
        step();
        scan_start = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            exp_d = 8'h01 << ((cyc - 1) / 2);
            check($sformatf("scan_c%0d_d", cyc), 64'(d), 64'(exp_d));
            check($sformatf("scan_c%0d_busy", cyc), 64'(scan_busy), 64'h1);
            check($sformatf("scan_c%0d_ready", cyc), 64'(in_ready), 64'h0);
            check($sformatf("scan_c%0d_ov", cyc), 64'(out_valid), 64'(((cyc - 1) % 2) == 0));
            step();
        end
        check("c17_d", 64'(d), 64'h00);
        check("c17_done", 64'(scan_done), 64'h1);
        check("c17_busy", 64'(scan_busy), 64'h0);
        check("c17_ready", 64'(in_ready), 64'h0);
        in_valid = 1'b0;
        step();
        check("c18_ready", 64'(in_ready), 64'h1);
        check("c18_done", 64'(scan_done), 64'h0);
        check("c18_d", 64'(d), 64'h00);

        // Reset mid-scan at code 3
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        for (int cyc = 1; cyc < 7; cyc++) step();
        check("mid_code3", 64'(d), 64'h08);
        reset = 1'b1;
        step();
        check("mid_rst_d", 64'(d), 64'h00);
        check("mid_rst_ready", 64'(in_ready), 64'h1);
        check("mid_rst_busy", 64'(scan_busy), 64'h0);
        reset = 1'b0;
        step();
        check("mid_after_d", 64'(d), 64'h00);
        check("mid_after_busy", 64'(scan_busy), 64'h0);
`else
        // Scan disabled: scan_start is inert and in_valid still decodes in the same cycle
        scan_start = 1'b1;
        #1;
        check("noscan_ready", 64'(in_ready), 64'h1);
        step();
        check("noscan_busy", 64'(scan_busy), 64'h0);
        check("noscan_d", 64'(d), 64'h80);
        check("noscan_ov", 64'(out_valid), 64'h0);
        in_valid = 1'b1; in_addr = 3'd6;
        step();
        check("noscan_coll_d", 64'(d), 64'h40);
        check("noscan_coll_busy", 64'(scan_busy), 64'h0);
        in_valid = 1'b0; scan_start = 1'b0;
        step();
        check("noscan_done", 64'(scan_done), 64'h0);
`endif

        // Wide instance
        w_valid = 1'b1; w_addr = 5'd31;
        step();
        check("wide_31_d", 64'(w_d), 64'h8000_0000);
        check("wide_31_ov", 64'(w_ov), 64'h1);
        w_addr = 5'd0;
        step();
        check("wide_0_d", 64'(w_d), 64'h0000_0001);
        w_valid = 1'b0;
        step();
        check("wide_hold_d", 64'(w_d), 64'h0000_0001);
        check("wide_hold_ov", 64'(w_ov), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decoder_nto2n_seq.md
# decoder_nto2n_seq

Parametrised, registered N-to-2^N one-hot decoder with a valid/ready input handshake and a built-in sweep (scan) sequencer. It generalises the fixed 3-to-8 and 5-to-32 decoders to any address width and adds an autonomous mode that walks every output code with a programmable dwell per code. It sits between address-generating control logic and downstream select/enable lines, or drives lamp and strobe test patterns during bring-up.

## Interface
- N, default 3: address width; output width is 2^N. Legal range 1..6.
- DWELL, default 4: cycles each code is held in scan mode. Must be >= 1.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_addr is valid this cycle.
- in_ready  output  1  block accepts an address this cycle.
- in_addr  input  N  address to decode.
- scan_start  input  1  request a full sweep of all codes.
- scan_busy  output  1  a sweep is in progress.
- scan_done  output  1  one-cycle pulse when a sweep completes.
- D  output  2^N  registered one-hot output.
- out_valid  output  1  one-cycle pulse when D takes a new code.

## Operation
- The FSM has three states: IDLE, SCAN and DONE.
- in_ready = (state==IDLE) && !scan_start. This is combinational.
- **Direct decode (IDLE):**
  - An accepted handshake (in_valid && in_ready) sets D <= 1 << in_addr and out_valid <= 1.
  - D holds its value until the next accept, a scan, or reset.
  - Back-to-back accepts are legal every cycle.
- **Scan start (IDLE):**
  - scan_start loads code counter = 0 and dwell counter = 0, sets D <= 1, out_valid <= 1, and moves to SCAN.
  - scan_start has priority over in_valid in the same cycle. in_ready is 0 in that cycle, so the address is not consumed.
- **SCAN:**
  - The dwell counter increments each cycle. When it reaches DWELL-1:
    - If code < 2^N-1: code increments, dwell clears, D <= 1 << (code+1), and out_valid pulses.
    - If code == 2^N-1: go to DONE.
  - scan_start and in_valid are ignored in SCAN. scan_busy is 1.
- **DONE:** lasts one cycle. scan_done = 1, D <= 0, then return to IDLE.
- Counter widths: the code counter is N bits; the dwell counter is max(1, $clog2(DWELL)) bits. Neither wraps outside these rules.
- Reset at any point, including mid-scan, clears everything to the reset values on the next edge.

## Timing
- Reset values:
  - D = 0, out_valid = 0, scan_busy = 0, scan_done = 0.
  - State IDLE, so in_ready = 1 (given scan_start = 0).
- Direct latency: D and out_valid update on the edge after the accept cycle, i.e. 1 cycle.
- Scan latency:
  - Code k is visible from cycle 1 + k*DWELL through cycle (k+1)*DWELL after the scan_start cycle.
  - scan_done is asserted at cycle 2^N*DWELL + 1.
  - in_ready returns to 1 at cycle 2^N*DWELL + 2.
- scan_busy and scan_done are registered (state-decoded). out_valid is registered.
- DWELL = 1: each code is held one cycle and out_valid is high for every code.

## Configuration
- Macro: DECODER_SCAN_EN.
- Defined: the scan sequencer, dwell counter and the SCAN/DONE states are built as described above.
- Undefined:
  - No scan logic is synthesised. scan_start is ignored, and scan_busy and scan_done are tied 0.
  - in_ready = 1 constantly, and only direct decode exists.

## Test plan
All scenarios use N=3 and DWELL=2 unless stated.
- **Reset:** assert reset for 2 cycles -> D=8'h00, out_valid=0, scan_busy=0, scan_done=0, in_ready=1.
- **Single direct decode:** in_addr=5 with in_valid for 1 cycle ->
  - next cycle D=8'h20 and out_valid=1;
  - the following cycle out_valid=0 and D still 8'h20.
- **Back-to-back direct decode:** in_addr=0..7 on consecutive cycles with in_valid held -> D=01,02,04,...,80 on successive cycles, out_valid continuously 1.
- **Full scan:** scan_start pulse ->
  - D=01 for 2 cycles, then 02, ..., 80, each for 2 cycles (16 cycles total), scan_busy=1 throughout;
  - scan_done=1 on cycle 17 with D=00;
  - in_ready=0 until cycle 18.
- **Start collision and scan-time input:** scan_start and in_valid (in_addr=6) in the same cycle -> in_ready=0, scan begins with D=01, and D never shows 8'h40 out of sequence. in_valid asserted during the scan is also ignored.
- **Reset mid-scan, then wide instance:**
  - reset at code 3 -> D=00 and in_ready=1 next cycle.
  - With N=5, in_addr=31 -> D=32'h8000_0000.
  - Rebuild without DECODER_SCAN_EN -> scan_start has no effect and scan_busy stays 0.
